// File: rtl/snoop_arbiter_if.sv
// Snooper-side bus of the snoop arbiter: write stream, end-of-packet and
// the buffer-offer handshake between the snooper and the arbiter.
interface snoop_arbiter_if #(
    parameter int SN_FWD_DATA_WIDTH = 64,
    parameter int SN_FWD_ADDR_WIDTH = 9,
    parameter int INC_WIDTH         = 8
);
    logic [SN_FWD_ADDR_WIDTH-1:0] sn_addr;
    logic [SN_FWD_DATA_WIDTH-1:0] sn_wr_data;
    logic                         sn_wr_en;
    logic [INC_WIDTH-1:0]         sn_byte_inc;
    logic                         sn_done;
    logic                         rdy_for_sn;
    logic                         rdy_for_sn_ack;

    // Handshake: rdy_for_sn is the valid side and rdy_for_sn_ack the ready
    // side. A buffer changes hands on any rising clk edge where both are high.
    // Once raised, rdy_for_sn stays high until that edge. The ack may be held
    // high ahead of the offer.
    modport master (
        output sn_addr, sn_wr_data, sn_wr_en, sn_byte_inc, sn_done, rdy_for_sn_ack,
        input  rdy_for_sn
    );

    modport slave (
        input  sn_addr, sn_wr_data, sn_wr_en, sn_byte_inc, sn_done, rdy_for_sn_ack,
        output rdy_for_sn
    );
endinterface

// File: rtl/snoop_arbiter.sv
// Snoop arbiter: hands free per-core snoop buffers to the snooper in
// round-robin order. It locks the write stream to the claimed core until
// sn_done. It pre-arms the next buffer while a packet is in flight, so
// back-to-back packets need no gap cycle.
module snoop_arbiter #(
    parameter  int N_CORES           = 4,
    parameter  int SN_FWD_DATA_WIDTH = 64,
    parameter  int SN_FWD_ADDR_WIDTH = 9,
    parameter  int INC_WIDTH         = 8,
    localparam int SEL_WIDTH         = (N_CORES > 1) ? $clog2(N_CORES) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    snoop_arbiter_if.slave               sn,
    input  logic [N_CORES-1:0]           core_rdy,
    output logic [N_CORES-1:0]           core_claim,
    output logic [SN_FWD_ADDR_WIDTH-1:0] core_addr,
    output logic [SN_FWD_DATA_WIDTH-1:0] core_wr_data,
    output logic [INC_WIDTH-1:0]         core_byte_inc,
    output logic [N_CORES-1:0]           core_wr_en,
    output logic [N_CORES-1:0]           core_done,
    output logic                         grant_valid,
    output logic [SEL_WIDTH-1:0]         grant_sel,
    output logic                         stray_wr,
    output logic [1:0]                   dbg_state
);
    localparam int PW = SEL_WIDTH + 1;

    // The state encoding is {cur_valid, off_valid}.
    typedef enum logic [1:0] {
        NONE        = 2'b00,
        OFFER       = 2'b01,
        GRANT       = 2'b10,
        GRANT_OFFER = 2'b11
    } state_t;

    state_t               state_q, state_d;
    logic [SEL_WIDTH-1:0] cur_sel_q, cur_sel_d;
    logic [SEL_WIDTH-1:0] off_sel_q, off_sel_d;
    logic [SEL_WIDTH-1:0] rr_ptr_q, rr_ptr_d;

    logic                 cur_valid, off_valid, handshake;
    logic                 cur_valid_d, off_valid_d;
    logic                 hit;
    logic [SEL_WIDTH-1:0] hit_sel;
    logic [PW-1:0]        scan_idx;
    logic [PW-1:0]        nxt_ptr;

    assign cur_valid = (state_q == GRANT) || (state_q == GRANT_OFFER);
    assign off_valid = (state_q == OFFER) || (state_q == GRANT_OFFER);
    assign handshake = off_valid && sn.rdy_for_sn_ack;

    assign sn.rdy_for_sn = off_valid;
    assign grant_valid   = cur_valid;
    assign grant_sel     = cur_sel_q;
    assign dbg_state     = state_q;

    // Data path is a zero-latency broadcast. Only the strobes are steered.
    assign core_addr     = sn.sn_addr;
    assign core_wr_data  = sn.sn_wr_data;
    assign core_byte_inc = sn.sn_byte_inc;
    assign core_wr_en    = (sn.sn_wr_en && cur_valid) ? (N_CORES'(1) << cur_sel_q) : '0;
    assign core_done     = (sn.sn_done  && cur_valid) ? (N_CORES'(1) << cur_sel_q) : '0;

    // State, selection and round-robin registers; reset abandons any grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= NONE;
            cur_sel_q <= '0;
            off_sel_q <= '0;
            rr_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            cur_sel_q <= cur_sel_d;
            off_sel_q <= off_sel_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    // Next state: handshake or packet end, then the round-robin search for
    // the next buffer to offer.
    always_comb begin
        cur_valid_d = cur_valid;
        off_valid_d = off_valid;
        cur_sel_d   = cur_sel_q;
        off_sel_d   = off_sel_q;
        rr_ptr_d    = rr_ptr_q;
        core_claim  = '0;
        stray_wr    = 1'b0;
        hit         = 1'b0;
        hit_sel     = '0;
        scan_idx    = '0;
        nxt_ptr     = '0;

        if (handshake) begin
            // The offered core becomes the granted one. While granted, the
            // ack is expected only at packet end, so the previous packet's
            // done (routed above) coincides with this claim.
            core_claim  = N_CORES'(1) << off_sel_q;
            cur_sel_d   = off_sel_q;
            cur_valid_d = 1'b1;
            off_valid_d = 1'b0;
            if (cur_valid && !sn.sn_done) begin
                stray_wr = 1'b1;
            end
        end else if (cur_valid && sn.sn_done) begin
            cur_valid_d = 1'b0;
        end

        if (!cur_valid && (sn.sn_wr_en || sn.sn_done)) begin
            stray_wr = 1'b1;
        end

        // Only search with no offer standing. The granted core is skipped,
        // so its late core_rdy deassert cannot produce a double offer.
        if (!off_valid) begin
            for (int i = 0; i < N_CORES; i++) begin
                scan_idx = {1'b0, rr_ptr_q} + PW'(i);
                if (scan_idx >= PW'(N_CORES)) begin
                    scan_idx = scan_idx - PW'(N_CORES);
                end
                if (!hit && core_rdy[scan_idx[SEL_WIDTH-1:0]] &&
                    !(cur_valid && (scan_idx[SEL_WIDTH-1:0] == cur_sel_q))) begin
                    hit     = 1'b1;
                    hit_sel = scan_idx[SEL_WIDTH-1:0];
                end
            end
            if (hit) begin
                off_valid_d = 1'b1;
                off_sel_d   = hit_sel;
                nxt_ptr     = {1'b0, hit_sel} + PW'(1);
                if (nxt_ptr == PW'(N_CORES)) begin
                    nxt_ptr = '0;
                end
                rr_ptr_d = nxt_ptr[SEL_WIDTH-1:0];
            end
        end

        state_d = state_t'({cur_valid_d, off_valid_d});
    end
endmodule

// File: tb/tb_snoop_arbiter.sv
// Directed bench for snoop_arbiter (4 cores): covers offer/claim, routing,
// round robin, pre-armed back-to-back packets, stray writes and mid-packet
// reset.
module tb_snoop_arbiter;
    localparam int N  = 4;
    localparam int DW = 64;
    localparam int AW = 9;
    localparam int IW = 8;
    localparam int W  = N + AW + 1;   // {core_wr_en, core_addr, stray_wr}

    logic          clk;
    logic          rst;
    logic [N-1:0]  core_rdy;
    logic [N-1:0]  core_claim;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wr_data;
    logic [IW-1:0] core_byte_inc;
    logic [N-1:0]  core_wr_en;
    logic [N-1:0]  core_done;
    logic          grant_valid;
    logic [1:0]    grant_sel;
    logic          stray_wr;
    logic [1:0]    dbg_state;

    snoop_arbiter_if #(.SN_FWD_DATA_WIDTH(DW), .SN_FWD_ADDR_WIDTH(AW), .INC_WIDTH(IW)) sn ();

    snoop_arbiter #(
        .N_CORES(N), .SN_FWD_DATA_WIDTH(DW), .SN_FWD_ADDR_WIDTH(AW), .INC_WIDTH(IW)
    ) dut (
        .clk(clk), .rst(rst), .sn(sn.slave),
        .core_rdy(core_rdy), .core_claim(core_claim), .core_addr(core_addr),
        .core_wr_data(core_wr_data), .core_byte_inc(core_byte_inc),
        .core_wr_en(core_wr_en), .core_done(core_done),
        .grant_valid(grant_valid), .grant_sel(grant_sel),
        .stray_wr(stray_wr), .dbg_state(dbg_state)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_pass   = 0;

    logic [W-1:0]  exp_q[$];    // expected write routing, one per sn_wr_en cycle
    logic [N-1:0]  claim_q[$];  // expected core_claim pulses, in order
    logic [DW-1:0] data_v;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst               = 1'b1;
        core_rdy          = '0;
        sn.sn_addr        = '0;
        sn.sn_wr_data     = '0;
        sn.sn_wr_en       = 1'b0;
        sn.sn_byte_inc    = '0;
        sn.sn_done        = 1'b0;
        sn.rdy_for_sn_ack = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_offer(input string tag);
        for (int i = 0; i < 8; i++) begin
            if (sn.rdy_for_sn) break;
            tick();
        end
        check(tag, 64'(sn.rdy_for_sn), 64'd1);
    endtask

    // Scoreboard: pops expectations as the DUT produces claims and writes.
    always @(negedge clk) begin
        if (!rst) begin
            if (core_claim != '0) begin
                if (claim_q.size() == 0) check("claim_unexpected", 64'(core_claim), 64'd0);
                else check("claim", 64'(core_claim), 64'(claim_q.pop_front()));
            end
            if (sn.sn_wr_en) begin
                if (exp_q.size() == 0) check("wr_unexpected", 64'({core_wr_en, core_addr, stray_wr}), 64'd0);
                else check("wr_route", 64'({core_wr_en, core_addr, stray_wr}), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        logic [N-1:0] cur_v, nxt_v;

        // Reset state
        do_reset();
        #1;
        check("rst_rdy", 64'(sn.rdy_for_sn), 64'd0);
        check("rst_gv", 64'(grant_valid), 64'd0);
        check("rst_gsel", 64'(grant_sel), 64'd0);
        check("rst_outs", 64'({core_claim, core_wr_en, core_done, stray_wr}), 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);
        check("rst_data", 64'(core_wr_data), 64'd0);

        // Single core, ack held high; offer rises one cycle after core_rdy
        core_rdy = 4'b0001;
        sn.rdy_for_sn_ack = 1'b1;
        claim_q.push_back(4'b0001);
        #1;
        check("t1_no_offer_yet", 64'(sn.rdy_for_sn), 64'd0);
        tick();
        check("t1_offer", 64'(sn.rdy_for_sn), 64'd1);
        tick();
        sn.rdy_for_sn_ack = 1'b0;
        check("t1_gv", 64'(grant_valid), 64'd1);
        check("t1_gsel", 64'(grant_sel), 64'd0);
        check("t1_no_self_offer", 64'(sn.rdy_for_sn), 64'd0);
        core_rdy = 4'b0000;
        data_v = {$urandom, $urandom};
        sn.sn_wr_data  = data_v;
        sn.sn_byte_inc = 8'd8;
        for (int a = 0; a < 4; a++) begin
            sn.sn_wr_en = 1'b1;
            sn.sn_addr  = AW'(a);
            exp_q.push_back({4'b0001, AW'(a), 1'b0});
            #1;
            check("t1_data", 64'(core_wr_data), 64'(data_v));
            check("t1_inc", 64'(core_byte_inc), 64'd8);
            tick();
        end
        sn.sn_wr_en = 1'b0;

        // Packet end with nothing else ready, then a stray write
        sn.sn_done = 1'b1;
        #1;
        check("t4_done", 64'(core_done), 64'b0001);
        check("t4_no_stray", 64'(stray_wr), 64'd0);
        tick();
        sn.sn_done = 1'b0;
        check("t4_gv", 64'(grant_valid), 64'd0);
        check("t4_rdy", 64'(sn.rdy_for_sn), 64'd0);
        sn.sn_wr_en = 1'b1;
        sn.sn_addr  = 9'd5;
        exp_q.push_back({4'b0000, 9'd5, 1'b1});
        #1;
        check("t4_stray", 64'(stray_wr), 64'd1);
        tick();
        sn.sn_wr_en = 1'b0;

        // Round robin over 5 back-to-back packets: 0,1,2,3,0
        do_reset();
        core_rdy = 4'b1111;
        wait_offer("rr_first_offer");
        sn.rdy_for_sn_ack = 1'b1;
        claim_q.push_back(4'b0001);
        tick();
        sn.rdy_for_sn_ack = 1'b0;
        check("rr_gsel0", 64'(grant_sel), 64'd0);
        for (int p = 1; p <= 4; p++) begin
            cur_v = 4'(1) << ((p - 1) % 4);
            nxt_v = 4'(1) << (p % 4);
            wait_offer("rr_prearm");
            check("rr_gv_inflight", 64'(grant_valid), 64'd1);
            sn.sn_wr_en = 1'b1;
            sn.sn_addr  = AW'(p);
            exp_q.push_back({cur_v, AW'(p), 1'b0});
            tick();
            sn.sn_wr_en = 1'b0;
            sn.sn_done = 1'b1;
            sn.rdy_for_sn_ack = 1'b1;
            claim_q.push_back(nxt_v);
            #1;
            check("rr_done", 64'(core_done), 64'(cur_v));
            tick();
            sn.sn_done = 1'b0;
            sn.rdy_for_sn_ack = 1'b0;
            check("rr_gsel", 64'(grant_sel), 64'(p % 4));
            check("rr_no_gap", 64'(grant_valid), 64'd1);
        end

        // Granted core keeps core_rdy high: never re-offered; ack without done
        do_reset();
        core_rdy = 4'b0010;
        wait_offer("t5_offer");
        sn.rdy_for_sn_ack = 1'b1;
        claim_q.push_back(4'b0010);
        tick();
        sn.rdy_for_sn_ack = 1'b0;
        check("t5_gsel", 64'(grant_sel), 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_no_self_offer", 64'(sn.rdy_for_sn), 64'd0);
        end
        core_rdy = 4'b1010;
        wait_offer("t5_offer3");
        sn.rdy_for_sn_ack = 1'b1;
        claim_q.push_back(4'b1000);
        #1;
        check("t5_ack_stray", 64'(stray_wr), 64'd1);
        check("t5_ack_no_done", 64'(core_done), 64'd0);
        tick();
        sn.rdy_for_sn_ack = 1'b0;
        check("t5_gsel3", 64'(grant_sel), 64'd3);

        // Core 2 readies mid-packet on core 0; seamless handover
        do_reset();
        core_rdy = 4'b0001;
        wait_offer("t3_offer0");
        sn.rdy_for_sn_ack = 1'b1;
        claim_q.push_back(4'b0001);
        tick();
        sn.rdy_for_sn_ack = 1'b0;
        core_rdy = 4'b0000;
        sn.sn_wr_en = 1'b1;
        sn.sn_addr  = 9'd7;
        exp_q.push_back({4'b0001, 9'd7, 1'b0});
        tick();
        sn.sn_wr_en = 1'b0;
        core_rdy = 4'b0100;
        wait_offer("t3_offer2");
        check("t3_gsel_inflight", 64'(grant_sel), 64'd0);
        sn.sn_done = 1'b1;
        sn.rdy_for_sn_ack = 1'b1;
        claim_q.push_back(4'b0100);
        #1;
        check("t3_done", 64'(core_done), 64'b0001);
        tick();
        sn.sn_done = 1'b0;
        sn.rdy_for_sn_ack = 1'b0;
        core_rdy = 4'b0000;
        check("t3_gsel2", 64'(grant_sel), 64'd2);
        check("t3_no_gap", 64'(grant_valid), 64'd1);

        // Reset while in GRANT_OFFER; search restarts from index 0
        core_rdy = 4'b0010;
        wait_offer("t6_offer1");
        check("t6_state", 64'(dbg_state), 64'd3);
        rst = 1'b1;
        core_rdy = 4'b0000;
        tick();
        check("t6_outs", 64'({sn.rdy_for_sn, grant_valid, grant_sel, core_claim,
                              core_wr_en, core_done, stray_wr}), 64'd0);
        rst = 1'b0;
        core_rdy = 4'b1001;
        wait_offer("t6_offer_after_rst");
        sn.rdy_for_sn_ack = 1'b1;
        claim_q.push_back(4'b0001);
        tick();
        sn.rdy_for_sn_ack = 1'b0;
        check("t6_gsel", 64'(grant_sel), 64'd0);

        tick();
        check("claim_q_empty", 64'(claim_q.size()), 64'd0);
        check("exp_q_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
